// File: rtl/alu_instr_sequencer.sv
// Hardwired fetch/decode/execute control sequencer for the DataPath: one control
// step per clock, memory wait-states, and two-step HI/LO write-back for MUL/DIV.
module alu_instr_sequencer #(
    parameter int             NUM_REGS    = 16,
    parameter int             OPW         = 5,
    parameter logic [OPW-1:0] MUL_OPC     = 5'b01111,
    parameter logic [OPW-1:0] DIV_OPC     = 5'b10000,
    parameter logic [OPW-1:0] NEG_OPC     = 5'b10001,
    parameter logic [OPW-1:0] NOT_OPC     = 5'b10010,
    parameter logic [OPW-1:0] MAX_BIN_OPC = 5'b01110,
    parameter int             CNT_W       = 16
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                start,
    input  logic                mem_ready,
    input  logic [31:0]         IR,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                Zin,
    output logic                PCin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                LOin,
    output logic                HIin,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic [OPW-1:0]      Operator,
    output logic                busy,
    output logic                done,
    output logic                illegal,
    output logic [CNT_W-1:0]    retired
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_TW   = 4'd3,
        ST_T2   = 4'd4,
        ST_T3   = 4'd5,
        ST_T4   = 4'd6,
        ST_T5   = 4'd7,
        ST_T6   = 4'd8,
        ST_DONE = 4'd9
    } state_t;

    state_t           state_r;
    logic             illegal_r;
    logic [CNT_W-1:0] retired_r;

    logic [OPW-1:0] opcode_s;
    logic [3:0]     ra_s;
    logic [3:0]     rb_s;
    logic [3:0]     rc_s;
    logic           is_muldiv_s;
    logic           is_binary_s;
    logic           is_unary_s;
    logic           bad_s;
    logic           unused_ir_s;

    // One-hot register select; a field outside the register file selects nothing.
    function automatic logic [NUM_REGS-1:0] reg_sel(input logic [3:0] field);
        logic [NUM_REGS-1:0] one_v;
        one_v = {{(NUM_REGS-1){1'b0}}, 1'b1};
        return one_v << field;
    endfunction

    function automatic logic reg_ok(input logic [3:0] field);
        return (32'(field) < NUM_REGS);
    endfunction

    assign opcode_s    = OPW'(IR[31:27]);
    assign ra_s        = IR[26:23];
    assign rb_s        = IR[22:19];
    assign rc_s        = IR[18:15];
    assign unused_ir_s = ^IR[14:0];

    // Instruction class and legality; Ra is don't-care for MUL/DIV since the result lands in HI/LO.
    always_comb begin
        is_muldiv_s = (opcode_s == MUL_OPC) || (opcode_s == DIV_OPC);
        is_binary_s = (opcode_s <= MAX_BIN_OPC) || is_muldiv_s;
        is_unary_s  = (opcode_s == NEG_OPC) || (opcode_s == NOT_OPC);
        if (is_binary_s) begin
            bad_s = !reg_ok(rb_s) || !reg_ok(rc_s) || (!is_muldiv_s && !reg_ok(ra_s));
        end else if (is_unary_s) begin
            bad_s = !reg_ok(ra_s) || !reg_ok(rb_s);
        end else begin
            bad_s = 1'b1;
        end
    end

    // Control-step sequencing, sticky illegal flag and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_r   <= ST_IDLE;
            illegal_r <= 1'b0;
            retired_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r   <= ST_T0;
                        illegal_r <= 1'b0;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_T0: state_r <= ST_T1;
                ST_T1: state_r <= mem_ready ? ST_T2 : ST_TW;
                ST_TW: state_r <= mem_ready ? ST_T2 : ST_TW;
                ST_T2: state_r <= ST_T3;
                ST_T3: begin
                    if (bad_s) begin
                        illegal_r <= 1'b1;
                        state_r   <= ST_DONE;
                    end else begin
                        state_r   <= ST_T4;
                    end
                end
                ST_T4: state_r <= ST_T5;
                ST_T5: state_r <= is_muldiv_s ? ST_T6 : ST_DONE;
                ST_T6: state_r <= ST_DONE;
                ST_DONE: begin
                    if (!illegal_r) begin
                        retired_r <= retired_r + CNT_W'(1);
                    end else begin
                        retired_r <= retired_r;
                    end
                    state_r <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // DataPath strobes decoded from the current control step and the IR.
    always_comb begin
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        Zin      = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        LOin     = 1'b0;
        HIin     = 1'b0;
        Rin      = '0;
        Rout     = '0;
        Operator = '0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_r)
            ST_IDLE: busy = 1'b0;
            ST_T0: begin
                busy  = 1'b1;
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            ST_T1: begin
                busy    = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            ST_TW: begin
                busy  = 1'b1;
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            ST_T2: begin
                busy   = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                busy = 1'b1;
                if (!bad_s && is_binary_s) begin
                    Rout = reg_sel(rb_s);
                    Yin  = 1'b1;
                end else begin
                    Rout = '0;
                    Yin  = 1'b0;
                end
            end
            ST_T4: begin
                busy     = 1'b1;
                Operator = opcode_s;
                Zin      = 1'b1;
                if (is_binary_s) begin
                    Rout = reg_sel(rc_s);
                end else begin
                    Rout = reg_sel(rb_s);
                end
            end
            ST_T5: begin
                busy    = 1'b1;
                Zlowout = 1'b1;
                if (is_muldiv_s) begin
                    LOin = 1'b1;
                end else begin
                    Rin  = reg_sel(ra_s);
                end
            end
            ST_T6: begin
                busy     = 1'b1;
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    assign illegal = illegal_r;
    assign retired = retired_r;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Randomized bench for alu_instr_sequencer: a trace model built from the instruction
// class predicts every control step, the illegal flag and the retired count.
module tb_alu_instr_sequencer;

    localparam int NR = 8;
    localparam logic [4:0] MUL  = 5'b01111;
    localparam logic [4:0] DIV  = 5'b10000;
    localparam logic [4:0] NEG  = 5'b10001;
    localparam logic [4:0] NOT  = 5'b10010;
    localparam logic [4:0] MAXB = 5'b01110;

    localparam logic [13:0] B_PCOUT = 14'h2000;
    localparam logic [13:0] B_MARIN = 14'h1000;
    localparam logic [13:0] B_INCPC = 14'h0800;
    localparam logic [13:0] B_ZIN   = 14'h0400;
    localparam logic [13:0] B_PCIN  = 14'h0200;
    localparam logic [13:0] B_READ  = 14'h0100;
    localparam logic [13:0] B_MDRIN = 14'h0080;
    localparam logic [13:0] B_MDROUT= 14'h0040;
    localparam logic [13:0] B_IRIN  = 14'h0020;
    localparam logic [13:0] B_YIN   = 14'h0010;
    localparam logic [13:0] B_ZLOW  = 14'h0008;
    localparam logic [13:0] B_ZHIGH = 14'h0004;
    localparam logic [13:0] B_LOIN  = 14'h0002;
    localparam logic [13:0] B_HIIN  = 14'h0001;

    logic clk = 1'b0;
    logic clear, start, mem_ready;
    logic [31:0] ir;
    logic PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin;
    logic Zlowout, Zhighout, LOin, HIin, busy, done, illegal;
    logic [NR-1:0] Rin, Rout;
    logic [4:0] Operator;
    logic [15:0] retired;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_retired = 16'd0;
    logic [37:0] exp_q[$];

    alu_instr_sequencer #(.NUM_REGS(NR)) dut (
        .clk(clk), .clear(clear), .start(start), .mem_ready(mem_ready), .IR(ir),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .PCin(PCin),
        .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .LOin(LOin), .HIin(HIin),
        .Rin(Rin), .Rout(Rout), .Operator(Operator), .busy(busy), .done(done),
        .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [37:0] observe();
        return {PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
                Zlowout, Zhighout, LOin, HIin, Rin, Rout, Operator, busy, done, illegal};
    endfunction

    function automatic logic [NR-1:0] oh(input int idx);
        logic [NR-1:0] v;
        v = '0;
        if (idx < NR) v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [37:0] step(input logic [13:0] s, input logic [NR-1:0] ri,
                                         input logic [NR-1:0] ro, input logic [4:0] op,
                                         input logic dn, input logic il);
        return {s, ri, ro, op, 1'b1, dn, il};
    endfunction

    function automatic logic [31:0] mkir(input logic [4:0] opc, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [3:0] rc);
        return {opc, ra, rb, rc, 15'h0000};
    endfunction

    // Expected per-cycle outputs of one instruction, from fetch to the done pulse.
    task automatic build_trace(input logic [31:0] instr, input int waits, output bit bad);
        logic [4:0] opc;
        int ra, rb, rc;
        bit md, bin, un;
        opc = instr[31:27];
        ra  = int'(instr[26:23]);
        rb  = int'(instr[22:19]);
        rc  = int'(instr[18:15]);
        md  = (opc == MUL) || (opc == DIV);
        bin = (opc <= MAXB) || md;
        un  = (opc == NEG) || (opc == NOT);
        bad = !(bin || un) || (rb >= NR) || (bin && rc >= NR) || (!md && ra >= NR);
        exp_q.delete();
        exp_q.push_back(step(B_PCOUT | B_MARIN | B_INCPC | B_ZIN, '0, '0, 5'd0, 1'b0, 1'b0));
        exp_q.push_back(step(B_ZLOW | B_PCIN | B_READ | B_MDRIN, '0, '0, 5'd0, 1'b0, 1'b0));
        for (int w = 0; w < waits; w++)
            exp_q.push_back(step(B_READ | B_MDRIN, '0, '0, 5'd0, 1'b0, 1'b0));
        exp_q.push_back(step(B_MDROUT | B_IRIN, '0, '0, 5'd0, 1'b0, 1'b0));
        if (bad) begin
            exp_q.push_back(step(14'h0, '0, '0, 5'd0, 1'b0, 1'b0));
            exp_q.push_back(step(14'h0, '0, '0, 5'd0, 1'b1, 1'b1));
        end else begin
            if (bin) exp_q.push_back(step(B_YIN, '0, oh(rb), 5'd0, 1'b0, 1'b0));
            else     exp_q.push_back(step(14'h0, '0, '0, 5'd0, 1'b0, 1'b0));
            exp_q.push_back(step(B_ZIN, '0, oh(bin ? rc : rb), opc, 1'b0, 1'b0));
            if (md) begin
                exp_q.push_back(step(B_ZLOW | B_LOIN, '0, '0, 5'd0, 1'b0, 1'b0));
                exp_q.push_back(step(B_ZHIGH | B_HIIN, '0, '0, 5'd0, 1'b0, 1'b0));
            end else begin
                exp_q.push_back(step(B_ZLOW, oh(ra), '0, 5'd0, 1'b0, 1'b0));
            end
            exp_q.push_back(step(14'h0, '0, '0, 5'd0, 1'b1, 1'b0));
        end
    endtask

    // Runs one instruction; abort_k > 0 asserts clear during that cycle of the instruction.
    task automatic run_instr(input logic [31:0] instr, input int waits, input int abort_k,
                             input string tag);
        bit bad;
        int n;
        build_trace(instr, waits, bad);
        n = exp_q.size();
        @(negedge clk);
        ir = instr;
        start = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        for (int k = 1; k <= n; k++) begin
            start = 1'($urandom_range(0, 1));
            mem_ready = (k >= 2 + waits);
            clear = (k == abort_k);
            @(negedge clk);
            check_eq($sformatf("%s_cyc%0d", tag, k), 64'(observe()), 64'(exp_q[k-1]));
            @(posedge clk); #1;
            if (k == abort_k) begin
                clear = 1'b0;
                start = 1'b0;
                @(negedge clk);
                check_eq($sformatf("%s_abort", tag), 64'({observe(), retired}), 64'd0);
                exp_retired = 16'd0;
                return;
            end
        end
        start = 1'b0;
        @(negedge clk);
        check_eq($sformatf("%s_idle", tag), 64'(observe()), {63'd0, bad});
        if (!bad) exp_retired = exp_retired + 16'd1;
        check_eq($sformatf("%s_retired", tag), 64'(retired), 64'(exp_retired));
    endtask

    function automatic logic [3:0] rand_reg();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(8, 15));
        return 4'($urandom_range(0, 7));
    endfunction

    function automatic logic [4:0] rand_opc();
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: return 5'($urandom_range(0, 14));
            6:                return ($urandom_range(0, 1) == 0) ? MUL : DIV;
            7:                return ($urandom_range(0, 1) == 0) ? NEG : NOT;
            8:                return 5'($urandom_range(19, 31));
            default:          return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        logic [31:0] instr;
        int waits, abort_k;
        clear = 1'b1;
        start = 1'b0;
        mem_ready = 1'b0;
        ir = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        @(negedge clk);
        check_eq("reset_outputs", 64'(observe()), 64'd0);
        check_eq("reset_retired", 64'(retired), 64'd0);
        clear = 1'b0;
        start = 1'b0;

        run_instr(32'h19A10000, 0, 0, "add");
        run_instr(32'h19A10000, 3, 0, "add_wait3");
        run_instr(mkir(MUL, 4'd15, 4'd5, 4'd6), 0, 0, "mul");
        run_instr(mkir(DIV, 4'd2, 4'd7, 4'd0), 1, 0, "div");
        run_instr(mkir(NEG, 4'd7, 4'd1, 4'd0), 0, 0, "neg");
        run_instr(mkir(NOT, 4'd0, 4'd7, 4'd15), 2, 0, "not_rc_ignored");
        run_instr(mkir(5'b11111, 4'd1, 4'd2, 4'd3), 0, 0, "illegal_opc");
        run_instr(mkir(5'd3, 4'd1, 4'd2, 4'd9), 0, 0, "illegal_rc9");
        run_instr(mkir(5'd0, 4'd8, 4'd2, 4'd3), 1, 0, "illegal_ra8");
        run_instr(mkir(DIV, 4'd0, 4'd1, 4'd8), 0, 0, "illegal_div_rc8");
        run_instr(mkir(5'd14, 4'd7, 4'd7, 4'd7), 0, 0, "maxbin_reg7");
        run_instr(32'h19A10000, 0, 5, "abort_t4");
        run_instr(mkir(5'd1, 4'd5, 4'd6, 4'd0), 0, 0, "after_abort");

        for (int i = 0; i < 60; i++) begin
            instr = {rand_opc(), rand_reg(), rand_reg(), rand_reg(), 15'($urandom)};
            waits = $urandom_range(0, 3);
            abort_k = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 5) : 0;
            run_instr(instr, waits, abort_k, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
